// File: rtl/keypad_scanner_if.sv
// Key event bus from the keypad scanner to the password-lock input logic.
// The scanner drives it through the master modport; consumers use the slave modport.
interface keypad_scanner_if;
    logic       keyboard_en;
    logic [3:0] keyboard_num;
    logic       key_held;

    modport master (output keyboard_en, output keyboard_num, output key_held);
    modport slave  (input  keyboard_en, input  keyboard_num, input  key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sync, press/release debounce, one pulse per key.
// Define KEYPAD_REPEAT_EN to enable auto-repeat pulses while a key is held.
module keypad_scanner #(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_DELAY = 64,
    parameter int REPEAT_RATE  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        row_n,
    output logic [3:0]        col_n,
    keypad_scanner_if.master  kb
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [3:0]    row_meta, row_sync;
    logic [1:0]    col_idx, col_nxt;
    logic [3:0]    code, code_nxt;
    logic [DW-1:0] deb_cnt, deb_nxt, deb_inc;
    logic [DW-1:0] rel_cnt, rel_nxt, rel_inc;
    logic          en_q, en_nxt;
    logic [3:0]    num_q, num_nxt;
    logic          any_low;
    logic [1:0]    low_row;
    logic          row_still_low;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam logic [RW-1:0] REP_FIRST  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE);
    logic [RW-1:0] rep_cnt, rep_nxt, rep_inc;
    assign rep_inc = rep_cnt + RW'(1);
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_DELAY > 0) && (REPEAT_RATE > 0);
`endif

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    // Lowest active row wins when several rows are pulled low at once.
    always_comb begin
        low_row = 2'd0;
        any_low = 1'b0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sync[r]) begin
                low_row = 2'(r);
                any_low = 1'b1;
            end
        end
    end

    assign row_still_low = !row_sync[code[3:2]];
    assign deb_inc = (deb_cnt == DEB_MAX) ? DEB_MAX : deb_cnt + DW'(1);
    assign rel_inc = (rel_cnt == DEB_MAX) ? DEB_MAX : rel_cnt + DW'(1);

    always_comb begin
        state_nxt = state;
        col_nxt   = col_idx;
        code_nxt  = code;
        deb_nxt   = deb_cnt;
        rel_nxt   = rel_cnt;
        en_nxt    = 1'b0;
        num_nxt   = num_q;
`ifdef KEYPAD_REPEAT_EN
        rep_nxt   = rep_cnt;
`endif
        case (state)
            SCAN: begin
                if (tick) begin
                    if (any_low) begin
                        code_nxt  = {low_row, col_idx};
                        deb_nxt   = DW'(1);
                        state_nxt = DEBOUNCE;
                    end else begin
                        col_nxt = col_idx + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (row_still_low) begin
                        if (deb_inc == DEB_MAX) begin
                            en_nxt    = 1'b1;
                            num_nxt   = code;
                            deb_nxt   = '0;
                            rel_nxt   = '0;
                            state_nxt = HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_nxt   = '0;
`endif
                        end else begin
                            deb_nxt = deb_inc;
                        end
                    end else begin
                        deb_nxt   = '0;
                        col_nxt   = col_idx + 2'd1;
                        state_nxt = SCAN;
                    end
                end
            end
            HELD: begin
                // Any low row in the frozen column, even a different one, keeps the key held.
                if (tick) begin
                    if (any_low) begin
                        rel_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
                        if (rep_inc == REP_FIRST) begin
                            en_nxt  = 1'b1;
                            num_nxt = code;
                            rep_nxt = REP_RELOAD;
                        end else begin
                            rep_nxt = rep_inc;
                        end
`endif
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        rep_nxt = '0;
`endif
                        if (rel_inc == DEB_MAX) begin
                            rel_nxt   = '0;
                            state_nxt = SCAN;
                        end else begin
                            rel_nxt = rel_inc;
                        end
                    end
                end
            end
            default: begin
                state_nxt = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= SCAN;
            col_idx <= 2'd0;
            code    <= 4'd0;
            deb_cnt <= '0;
            rel_cnt <= '0;
            en_q    <= 1'b0;
            num_q   <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt <= '0;
`endif
        end else begin
            state   <= state_nxt;
            col_idx <= col_nxt;
            code    <= code_nxt;
            deb_cnt <= deb_nxt;
            rel_cnt <= rel_nxt;
            en_q    <= en_nxt;
            num_q   <= num_nxt;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt <= rep_nxt;
`endif
        end
    end

    assign col_n           = ~(4'b0001 << col_idx);
    assign kb.keyboard_en  = en_q;
    assign kb.keyboard_num = num_q;
    assign kb.key_held     = (state == HELD);

endmodule
